// File: rtl/bsg_nonsynth_dramsim3_ch_req_queue.sv
// Per-channel in-order request FIFO ahead of the DRAMSim3 address mapper.
// Head issue is gated by a read-credit counter that read completions return.
module bsg_nonsynth_dramsim3_ch_req_queue #(
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned data_width_p         = 64,
  parameter int unsigned els_p                = 4,
  parameter int unsigned max_reads_p          = 8,
  localparam int unsigned lg_els_lp            = $clog2(els_p + 1),
  localparam int unsigned lg_reads_lp          = $clog2(max_reads_p + 1),
  localparam int unsigned mask_width_lp        = data_width_p >> 3,
  localparam int unsigned byte_offset_width_lp = (mask_width_lp > 1) ? $clog2(mask_width_lp) : 1,
  localparam int unsigned ptr_width_lp         = $clog2(els_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic                            write_not_read_i,
  input  logic [channel_addr_width_p-1:0] ch_addr_i,
  input  logic [data_width_p-1:0]         data_i,
  input  logic [mask_width_lp-1:0]        mask_i,
  output logic                            ready_o,
  output logic                            mem_v_o,
  output logic                            mem_write_not_read_o,
  output logic [channel_addr_width_p-1:0] mem_ch_addr_o,
  output logic [data_width_p-1:0]         mem_data_o,
  output logic [mask_width_lp-1:0]        mem_mask_o,
  input  logic                            mem_yumi_i,
  input  logic                            read_done_i,
  output logic [lg_els_lp-1:0]            count_o,
  output logic [lg_reads_lp-1:0]          reads_outstanding_o,
  output logic                            err_underflow_o
);

  localparam logic [channel_addr_width_p-1:0] addr_keep_lp =
    ~channel_addr_width_p'((64'd1 << byte_offset_width_lp) - 64'd1);

  logic                            r_wnr  [els_p];
  logic [channel_addr_width_p-1:0] r_addr [els_p];
  logic [data_width_p-1:0]         r_data [els_p];
  logic [mask_width_lp-1:0]        r_mask [els_p];

  logic [ptr_width_lp-1:0] r_wptr, r_rptr;
  logic [lg_els_lp-1:0]    r_count;
  logic [lg_reads_lp-1:0]  r_reads;
  logic                    r_err;
  logic                    r_rst;

  logic w_rst, w_enq, w_deq, w_rpop, w_done, w_head_ok;
  logic [ptr_width_lp-1:0] w_wptr_nxt, w_rptr_nxt;

  // Reset asserts immediately and releases on the first clock edge after reset_i falls.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_rst <= 1'b1;
    else         r_rst <= 1'b0;
  end

  assign w_rst     = reset_i | r_rst;
  assign w_head_ok = r_wnr[r_rptr] | (r_reads < lg_reads_lp'(max_reads_p));

  assign ready_o  = ~w_rst & (r_count < lg_els_lp'(els_p));
  assign mem_v_o  = ~w_rst & (r_count != '0) & w_head_ok;

  assign mem_write_not_read_o = r_wnr[r_rptr];
  assign mem_ch_addr_o        = r_addr[r_rptr];
  assign mem_data_o           = r_data[r_rptr];
  assign mem_mask_o           = r_mask[r_rptr];

  assign w_enq  = v_i & ready_o;
  assign w_deq  = mem_v_o & mem_yumi_i;
  assign w_rpop = w_deq & ~r_wnr[r_rptr];
  assign w_done = read_done_i & ~w_rst;

  assign w_wptr_nxt = (r_wptr == ptr_width_lp'(els_p - 1)) ? '0 : r_wptr + ptr_width_lp'(1);
  assign w_rptr_nxt = (r_rptr == ptr_width_lp'(els_p - 1)) ? '0 : r_rptr + ptr_width_lp'(1);

  // Entry storage; read entries carry a zero mask so the mapper never sees stray byte enables.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_wnr[r_wptr]  <= write_not_read_i;
      r_addr[r_wptr] <= ch_addr_i & addr_keep_lp;
      r_data[r_wptr] <= data_i;
      r_mask[r_wptr] <= write_not_read_i ? mask_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= w_wptr_nxt;
      if (w_deq) r_rptr <= w_rptr_nxt;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + lg_els_lp'(1);
        2'b01:   r_count <= r_count - lg_els_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read credits: a pop and a completion in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_reads <= '0;
      r_err   <= 1'b0;
    end else if (w_rpop & ~w_done) begin
      r_reads <= r_reads + lg_reads_lp'(1);
    end else if (w_done & ~w_rpop) begin
      if (r_reads == '0) r_err   <= 1'b1;
      else               r_reads <= r_reads - lg_reads_lp'(1);
    end
  end

  assign count_o             = r_count;
  assign reads_outstanding_o = r_reads;
  assign err_underflow_o     = r_err;

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_ch_req_queue.sv
// Directed bench for the channel request queue with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_bsg_nonsynth_dramsim3_ch_req_queue;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW >> 3;
  localparam int unsigned ELS = 4;
  localparam int unsigned MAXR = 2;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          v = 1'b0, wnr = 1'b0, yumi = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [MW-1:0] mask = '0;

  logic          ready_o, mem_v_o, mem_wnr_o, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [MW-1:0] mem_mask_o;
  logic [2:0]    count_o;
  logic [1:0]    reads_o;

  bsg_nonsynth_dramsim3_ch_req_queue #(
    .channel_addr_width_p(AW), .data_width_p(DW), .els_p(ELS), .max_reads_p(MAXR)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v), .write_not_read_i(wnr),
    .ch_addr_i(addr), .data_i(data), .mask_i(mask), .ready_o(ready_o),
    .mem_v_o(mem_v_o), .mem_write_not_read_o(mem_wnr_o), .mem_ch_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_yumi_i(yumi),
    .read_done_i(rd_done), .count_o(count_o), .reads_outstanding_o(reads_o),
    .err_underflow_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of requests plus a credit count.
  typedef struct {
    logic          wnr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } ent_t;

  ent_t q[$];
  int   m_out  = 0;
  bit   m_err  = 0;
  bit   m_hold = 0;
  bit   ex_v, ex_r, pop, rpop;

  function automatic bit exp_mv();
    return !m_hold && q.size() > 0 && (q[0].wnr || m_out < int'(MAXR));
  endfunction

  function automatic bit exp_ready();
    return !m_hold && q.size() < int'(ELS);
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      q.delete();
      m_out  = 0;
      m_err  = 0;
      m_hold = 1;
    end else if (m_hold) begin
      m_hold = 0;
    end else begin
      ex_v = exp_mv();
      ex_r = exp_ready();
      pop  = yumi && ex_v;
      rpop = pop && !q[0].wnr;
      if (pop) void'(q.pop_front());
      if (v && ex_r) q.push_back('{wnr, addr & 16'hFFF8, data, wnr ? mask : '0});
      if (rpop && !rd_done) m_out++;
      else if (rd_done && !rpop) begin
        if (m_out == 0) m_err = 1;
        else m_out--;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("ready", ready_o, exp_ready());
      chk("mem_v", mem_v_o, exp_mv());
      chk("count", count_o, q.size());
      chk("reads_out", reads_o, m_out);
      chk("err", err_o, m_err);
      if (exp_mv() && mem_v_o) begin
        chk("head_wnr", mem_wnr_o, q[0].wnr);
        chk("head_addr", mem_addr_o, q[0].addr);
        chk("head_mask", mem_mask_o, q[0].mask);
        if (q[0].wnr) chk("head_data", mem_data_o, q[0].data);
      end
    end
  end

  task automatic enq(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [MW-1:0] m);
    v = 1'b1; wnr = w; addr = a; data = d; mask = m;
    @(negedge clk);
    v = 1'b0;
  endtask

  task automatic pop_expect(input logic w, input logic [AW-1:0] a, input logic [MW-1:0] m);
    int n = 0;
    while (!mem_v_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pop_wait", mem_v_o, 1'b1);
    chk("pop_wnr", mem_wnr_o, w);
    chk("pop_addr", mem_addr_o, a);
    chk("pop_mask", mem_mask_o, m);
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset_i = 1'b1;
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_reads", reads_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk); #1 reset_i = 1'b0;
    @(negedge clk);

    // Reset mid-stream
    enq(1, 16'h0000, 64'hA0, 8'hFF);
    enq(1, 16'h0008, 64'hA1, 8'hFF);
    enq(1, 16'h0010, 64'hA2, 8'hFF);
    chk("t1_count3", count_o, 3);
    #2 reset_i = 1'b1;
    #1;
    chk("t1_async_count", count_o, 0);
    chk("t1_async_mem_v", mem_v_o, 0);
    chk("t1_async_ready", ready_o, 0);
    @(negedge clk); #1 reset_i = 1'b0;
    @(posedge clk); #1;
    chk("t1_ready_after", ready_o, 1);
    @(negedge clk);

    // Fill to full, then a push on a pop cycle is refused
    enq(1, 16'h0000, 64'hB0, 8'h01);
    enq(1, 16'h0008, 64'hB1, 8'h02);
    enq(1, 16'h0010, 64'hB2, 8'h04);
    enq(1, 16'h0018, 64'hB3, 8'h08);
    chk("t2_full_ready", ready_o, 0);
    chk("t2_full_count", count_o, 4);
    v = 1'b1; wnr = 1'b1; addr = 16'h0020; yumi = 1'b1;
    @(negedge clk);
    v = 1'b0; yumi = 1'b0;
    chk("t2_count3", count_o, 3);
    pop_expect(1, 16'h0008, 8'h02);
    pop_expect(1, 16'h0010, 8'h04);
    pop_expect(1, 16'h0018, 8'h08);
    chk("t2_empty", count_o, 0);

    // Ordering and address alignment
    enq(1, 16'h0040, 64'h1111_2222_3333_4444, 8'hF0);
    enq(0, 16'h0083, 64'hDEAD_BEEF, 8'hFF);
    enq(1, 16'h0105, 64'h5555_6666_7777_8888, 8'h0F);
    chk("t3_data0", mem_data_o, 64'h1111_2222_3333_4444);
    pop_expect(1, 16'h0040, 8'hF0);
    pop_expect(0, 16'h0080, 8'h00);
    chk("t3_data2", mem_data_o, 64'h5555_6666_7777_8888);
    pop_expect(1, 16'h0100, 8'h0F);
    chk("t3_reads1", reads_o, 1);
    rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
    chk("t3_reads0", reads_o, 0);

    // Credit block
    enq(0, 16'h0000, '0, '0);
    enq(0, 16'h0008, '0, '0);
    enq(0, 16'h0010, '0, '0);
    enq(1, 16'h0018, 64'hC3, 8'hAA);
    pop_expect(0, 16'h0000, 8'h00);
    pop_expect(0, 16'h0008, 8'h00);
    chk("t4_blocked", mem_v_o, 0);
    chk("t4_reads2", reads_o, 2);
    chk("t4_count2", count_o, 2);
    rd_done = 1'b1;
    #1 chk("t4_same_cycle", mem_v_o, 0);
    @(negedge clk); rd_done = 1'b0;
    chk("t4_unblocked", mem_v_o, 1);
    chk("t4_reads1", reads_o, 1);

    // Simultaneous read pop + completion, then enqueue + pop
    yumi = 1'b1; rd_done = 1'b1;
    @(negedge clk); yumi = 1'b0; rd_done = 1'b0;
    chk("t5_reads_hold", reads_o, 1);
    chk("t5_count1", count_o, 1);
    enq(1, 16'h0020, 64'hC4, 8'h55);
    chk("t5_count2", count_o, 2);
    v = 1'b1; wnr = 1'b1; addr = 16'h0028; data = 64'hC5; mask = 8'h33; yumi = 1'b1;
    @(negedge clk); v = 1'b0; yumi = 1'b0;
    chk("t5_count_hold", count_o, 2);
    pop_expect(1, 16'h0020, 8'h55);
    pop_expect(1, 16'h0028, 8'h33);
    rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
    chk("t5_reads0", reads_o, 0);
    chk("t5_no_err", err_o, 0);

    // Underflow is sticky
    rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
    chk("t6_err", err_o, 1);
    chk("t6_reads0", reads_o, 0);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", err_o, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
